emissions_sensor_scheduler: RTL and testbench

//  Round-robin poller that shares one CO2 level classifier among NUM_SENSORS exhaust sensor channels.

---
 rtl/emissions_pkg.sv | 24 ++
 rtl/emissions_level_classifier.sv | 22 ++
 rtl/emissions_sensor_scheduler.sv | 156 +++++++++++++++
 tb/tb_emissions_sensor_scheduler.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/emissions_pkg.sv
// Shared types and default tuning constants for the exhaust CO2 sensor scheduler.
package emissions_pkg;

   typedef enum logic [1:0] {
      NORMAL   = 2'd0,
      WARNING  = 2'd1,
      CRITICAL = 2'd2
   } level_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_GRANT,
      S_CLASSIFY,
      S_UPDATE
   } sched_state_t;

   localparam int unsigned DEF_NUM_SENSORS = 4;
   localparam int unsigned DEF_DATA_W      = 8;
   localparam int unsigned DEF_WARN_TH     = 50;
   localparam int unsigned DEF_CRIT_TH     = 100;
   localparam int unsigned DEF_PERSIST     = 3;
   localparam int unsigned DEF_TIMEOUT     = 15;

endpackage

// File: rtl/emissions_level_classifier.sv
// Combinational CO2 sample classifier: maps an unsigned sample onto NORMAL/WARNING/CRITICAL.
module emissions_level_classifier
   import emissions_pkg::*;
#(
   parameter int unsigned DATA_W  = DEF_DATA_W,
   parameter int unsigned WARN_TH = DEF_WARN_TH,
   parameter int unsigned CRIT_TH = DEF_CRIT_TH
)(
   input  logic [DATA_W-1:0] sample,
   output level_t            level
);

   always_comb begin
      if (32'(sample) >= CRIT_TH)
         level = CRITICAL;
      else if (32'(sample) >= WARN_TH)
         level = WARNING;
      else
         level = NORMAL;
   end

endmodule

// File: rtl/emissions_sensor_scheduler.sv
// Round-robin poller sharing one classifier across exhaust sensors, with per-channel persistence
// filtering, sticky timeout flags and registered alarm aggregation. Reset deassertion is expected to be synchronised upstream.
module emissions_sensor_scheduler
   import emissions_pkg::*;
#(
   parameter  int unsigned NUM_SENSORS = DEF_NUM_SENSORS,
   parameter  int unsigned DATA_W      = DEF_DATA_W,
   parameter  int unsigned WARN_TH     = DEF_WARN_TH,
   parameter  int unsigned CRIT_TH     = DEF_CRIT_TH,
   parameter  int unsigned PERSIST     = DEF_PERSIST,
   parameter  int unsigned TIMEOUT     = DEF_TIMEOUT,
   localparam int unsigned PTR_W       = $clog2(NUM_SENSORS)
)(
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          enable,
   input  logic [NUM_SENSORS*DATA_W-1:0] sensor_data,
   input  logic [NUM_SENSORS-1:0]        sensor_valid,
   output logic [NUM_SENSORS-1:0]        sensor_ready,
   input  logic [NUM_SENSORS-1:0]        clear_err,
   output logic [NUM_SENSORS-1:0]        timeout_err,
   output logic [2*NUM_SENSORS-1:0]      ch_level,
   output logic                          warning,
   output logic                          critical,
   output logic [PTR_W-1:0]              worst_ch
);

   localparam int unsigned WAIT_W  = $clog2(TIMEOUT + 1);
   localparam int unsigned CNT_W   = $clog2(PERSIST + 1);
   localparam logic [PTR_W-1:0] LAST_CH = PTR_W'(NUM_SENSORS - 1);

   sched_state_t            state_q, state_d;
   logic [PTR_W-1:0]        ptr_q, ptr_nxt;
   logic [WAIT_W-1:0]       wait_q;
   logic [DATA_W-1:0]       sample_q;
   level_t                  level_q, cls_level;
   level_t                  ch_lvl_q [NUM_SENSORS];
   level_t                  pend_q   [NUM_SENSORS];
   logic [CNT_W-1:0]        cnt_q    [NUM_SENSORS];
   logic [DATA_W-1:0]       data_arr [NUM_SENSORS];
   logic                    handshake, timeout_hit;
   logic [NUM_SENSORS-1:0]  tmo_mask;
   logic [CNT_W-1:0]        upd_cnt;
   logic                    any_crit, any_warn;
   level_t                  worst_lvl;
   logic [PTR_W-1:0]        worst_idx;

   for (genvar g = 0; g < NUM_SENSORS; g++) begin : g_ch
      assign data_arr[g]         = sensor_data[g*DATA_W +: DATA_W];
      assign ch_level[2*g +: 2]  = ch_lvl_q[g];
   end

   assign handshake   = (state_q == S_GRANT) && sensor_valid[ptr_q];
   assign timeout_hit = (state_q == S_GRANT) && !handshake && enable &&
                        (wait_q == WAIT_W'(TIMEOUT - 1));
   assign ptr_nxt     = (ptr_q == LAST_CH) ? '0 : ptr_q + 1'b1;

   emissions_level_classifier #(
      .DATA_W  (DATA_W),
      .WARN_TH (WARN_TH),
      .CRIT_TH (CRIT_TH)
   ) u_classifier (
      .sample (sample_q),
      .level  (cls_level)
   );

   // NOTE: every combinational output gets a default first so no path can infer a latch.
   always_comb begin
      state_d      = state_q;
      sensor_ready = '0;
      unique case (state_q)
         S_IDLE:     if (enable) state_d = S_GRANT;
         S_GRANT: begin
            sensor_ready[ptr_q] = 1'b1;
            if (handshake)   state_d = S_CLASSIFY;
            else if (!enable) state_d = S_IDLE;
         end
         S_CLASSIFY: state_d = S_UPDATE;
         S_UPDATE:   state_d = enable ? S_GRANT : S_IDLE;
         default:    state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      tmo_mask = '0;
      if (timeout_hit) tmo_mask[ptr_q] = 1'b1;
      if (level_q == pend_q[ptr_q])
         upd_cnt = (cnt_q[ptr_q] == CNT_W'(PERSIST)) ? cnt_q[ptr_q] : cnt_q[ptr_q] + 1'b1;
      else
         upd_cnt = CNT_W'(1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr_q       <= '0;
         wait_q      <= '0;
         sample_q    <= '0;
         level_q     <= NORMAL;
         timeout_err <= '0;
         // NOTE: the per-channel arrays are small flop banks that must power up NORMAL, so they are reset.
         for (int i = 0; i < NUM_SENSORS; i++) begin
            ch_lvl_q[i] <= NORMAL;
            pend_q[i]   <= NORMAL;
            cnt_q[i]    <= '0;
         end
      end else begin
         wait_q <= (state_q == S_GRANT && !handshake && enable && !timeout_hit) ?
                   wait_q + 1'b1 : '0;
         if (handshake)              sample_q <= data_arr[ptr_q];
         if (state_q == S_CLASSIFY)  level_q  <= cls_level;
         if (state_q == S_UPDATE) begin
            pend_q[ptr_q] <= level_q;
            cnt_q[ptr_q]  <= upd_cnt;
            if (upd_cnt == CNT_W'(PERSIST)) ch_lvl_q[ptr_q] <= level_q;
         end
         if (state_q == S_UPDATE || timeout_hit) ptr_q <= ptr_nxt;
         // A timeout in the same cycle as a clear re-sets the flag.
         timeout_err <= (timeout_err & ~clear_err) | tmo_mask;
      end
   end

   // Descending scan with >= leaves the lowest index holding the highest level.
   always_comb begin
      any_crit  = 1'b0;
      any_warn  = 1'b0;
      worst_lvl = NORMAL;
      worst_idx = '0;
      for (int i = NUM_SENSORS - 1; i >= 0; i--) begin
         if (ch_lvl_q[i] == CRITICAL) any_crit = 1'b1;
         if (ch_lvl_q[i] == WARNING)  any_warn = 1'b1;
         if (ch_lvl_q[i] >= worst_lvl) begin
            worst_lvl = ch_lvl_q[i];
            worst_idx = PTR_W'(i);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         critical <= 1'b0;
         warning  <= 1'b0;
         worst_ch <= '0;
      end else begin
         critical <= any_crit;
         warning  <= any_warn && !any_crit;
         worst_ch <= worst_idx;
      end
   end

endmodule

// File: tb/tb_emissions_sensor_scheduler.sv
// Self-checking bench: transaction-level reference model plus directed scenarios and randomized traffic.
module tb_emissions_sensor_scheduler;

   localparam int N   = 4;
   localparam int DW  = 8;
   localparam int WTH = 50;
   localparam int CTH = 100;
   localparam int P   = 3;
   localparam int TMO = 15;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            enable = 1'b0;
   logic [N*DW-1:0] sensor_data = '0;
   logic [N-1:0]    sensor_valid = '0;
   logic [N-1:0]    clear_err = '0;
   logic [N-1:0]    sensor_ready;
   logic [N-1:0]    timeout_err;
   logic [2*N-1:0]  ch_level;
   logic            warning;
   logic            critical;
   logic [1:0]      worst_ch;

   always #5 clk = ~clk;

   emissions_sensor_scheduler #(
      .NUM_SENSORS (N),
      .DATA_W      (DW),
      .WARN_TH     (WTH),
      .CRIT_TH     (CTH),
      .PERSIST     (P),
      .TIMEOUT     (TMO)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .sensor_data  (sensor_data),
      .sensor_valid (sensor_valid),
      .sensor_ready (sensor_ready),
      .clear_err    (clear_err),
      .timeout_err  (timeout_err),
      .ch_level     (ch_level),
      .warning      (warning),
      .critical     (critical),
      .worst_ch     (worst_ch)
   );

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (levels: 0 normal, 1 warning, 2 critical)
   int m_lvl[N], m_pend[N], m_run[N], m_acc[N], m_tmo[N];
   bit m_err[N];
   bit m_granting;
   int m_ptr, m_waited, m_busy, m_ch, m_sample;
   bit m_crit, m_warn;
   int m_worst;

   function automatic int classify(input int s);
      if (s >= CTH) return 2;
      if (s >= WTH) return 1;
      return 0;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_lvl[i] = 0; m_pend[i] = 0; m_run[i] = 0; m_err[i] = 1'b0;
      end
      m_granting = 1'b0; m_ptr = 0; m_waited = 0; m_busy = 0;
      m_ch = 0; m_sample = 0; m_crit = 1'b0; m_warn = 1'b0; m_worst = 0;
   endtask

   task automatic model_step();
      int top, lv;
      // alarms always describe the levels committed before this edge
      top = 0; m_worst = 0;
      for (int i = 0; i < N; i++)
         if (m_lvl[i] > top) begin top = m_lvl[i]; m_worst = i; end
      m_crit = (top == 2);
      m_warn = (top == 1);
      for (int i = 0; i < N; i++)
         if (clear_err[i]) m_err[i] = 1'b0;
      if (m_busy == 2) begin
         m_busy = 1;
      end else if (m_busy == 1) begin
         lv = classify(m_sample);
         if (lv == m_pend[m_ch]) m_run[m_ch] = (m_run[m_ch] + 1 > P) ? P : m_run[m_ch] + 1;
         else begin m_pend[m_ch] = lv; m_run[m_ch] = 1; end
         if (m_run[m_ch] == P) m_lvl[m_ch] = m_pend[m_ch];
         m_ptr = (m_ptr + 1) % N;
         m_busy = 0;
         m_granting = enable;
      end else if (m_granting) begin
         if (sensor_valid[m_ptr]) begin
            m_ch = m_ptr;
            m_sample = int'(sensor_data[m_ptr*DW +: DW]);
            m_busy = 2; m_granting = 1'b0; m_waited = 0;
            m_acc[m_ptr]++;
         end else if (!enable) begin
            m_granting = 1'b0; m_waited = 0;
         end else if (m_waited == TMO - 1) begin
            m_err[m_ptr] = 1'b1;
            m_tmo[m_ptr]++;
            m_ptr = (m_ptr + 1) % N;
            m_waited = 0;
         end else begin
            m_waited++;
         end
      end else if (enable) begin
         m_granting = 1'b1;
      end
   endtask

   initial begin
      for (int i = 0; i < N; i++) begin m_acc[i] = 0; m_tmo[i] = 0; end
      model_reset();
      forever begin
         @(posedge clk or negedge reset);
         if (!reset) model_reset();
         else        model_step();
      end
   end

   // ---------------- per-cycle comparison
   initial begin
      forever begin
         @(negedge clk);
         if (cmp_en) begin
            check("ready", int'(sensor_ready), m_granting ? (1 << m_ptr) : 0);
            for (int i = 0; i < N; i++) begin
               check($sformatf("timeout_err%0d", i), int'(timeout_err[i]), int'(m_err[i]));
               check($sformatf("ch_level%0d", i), int'(ch_level[2*i +: 2]), m_lvl[i]);
            end
            check("warning", int'(warning), int'(m_warn));
            check("critical", int'(critical), int'(m_crit));
            check("worst_ch", int'(worst_ch), m_worst);
         end
      end
   end

   // ---------------- stimulus helpers
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_data(input int ch, input int val);
      sensor_data[ch*DW +: DW] = 8'(val);
   endtask

   function automatic int acc_total();
      int s = 0;
      for (int i = 0; i < N; i++) s += m_acc[i];
      return s;
   endfunction

   task automatic wait_acc(input int ch, input int target);
      int n = 0;
      while (m_acc[ch] < target && n < 400) begin @(negedge clk); n++; end
      if (m_acc[ch] < target) check($sformatf("wait_acc_ch%0d", ch), m_acc[ch], target);
   endtask

   task automatic wait_any_acc();
      int b = acc_total();
      int n = 0;
      while (acc_total() == b && n < 400) begin @(negedge clk); n++; end
      if (acc_total() == b) check("wait_any_acc", acc_total(), b + 1);
   endtask

   function automatic int lvl_of(input int ch);
      return int'(ch_level[2*ch +: 2]);
   endfunction

   initial begin
      int b, n, t;
      int vprob[N];

      #1 reset = 1'b0;
      @(negedge clk);
      check("rst_ready", int'(sensor_ready), 0);
      check("rst_ch_level", int'(ch_level), 0);
      check("rst_warning", int'(warning), 0);
      check("rst_critical", int'(critical), 0);
      check("rst_timeout_err", int'(timeout_err), 0);
      check("rst_worst_ch", int'(worst_ch), 0);
      cmp_en = 1'b1;
      reset  = 1'b1;

      // 1: ch2 critical, others normal, all always valid
      sensor_valid = '1;
      set_data(0, 30); set_data(1, 30); set_data(2, 120); set_data(3, 30);
      enable = 1'b1;
      wait_acc(2, 3);
      check("t1_lvl2_k", lvl_of(2), 0);
      tick(1);
      check("t1_lvl2_k1", lvl_of(2), 0);
      tick(1);
      check("t1_lvl2_k2", lvl_of(2), 2);
      check("t1_crit_k2", int'(critical), 0);
      tick(1);
      check("t1_crit_k3", int'(critical), 1);
      check("t1_warn_k3", int'(warning), 0);
      check("t1_worst_k3", int'(worst_ch), 2);

      // 2: ch1 99,99,99 then 100,100,100
      set_data(2, 30);
      b = m_acc[1];
      set_data(1, 99);
      wait_acc(1, b + 3); tick(2);
      check("t2_warn", lvl_of(1), 1);
      set_data(1, 100);
      wait_acc(1, b + 5); tick(2);
      check("t2_hold_warn", lvl_of(1), 1);
      wait_acc(1, b + 6); tick(2);
      check("t2_crit", lvl_of(1), 2);

      // 3: ch0 alternating 49/51 never commits, then exactly WARN_TH commits WARNING
      b = m_acc[0];
      for (int k = 0; k < 4; k++) begin
         set_data(0, (k % 2 == 0) ? 49 : 51);
         wait_acc(0, b + k + 1); tick(2);
         check($sformatf("t3_alt%0d", k), lvl_of(0), 0);
      end
      set_data(0, 50);
      wait_acc(0, b + 6); tick(2);
      check("t3_exact_warn", lvl_of(0), 1);

      // 4: ch3 silent -> timeout after 15 grant cycles, clear, and timeout-beats-clear
      sensor_valid = 4'b0111;
      n = 0;
      while (sensor_ready != 4'b1000 && n < 100) begin @(negedge clk); n++; end
      t = 0;
      while (sensor_ready == 4'b1000 && t < 40) begin @(negedge clk); t++; end
      check("t4_grant_cycles", t, 15);
      check("t4_wrap", int'(sensor_ready), 1);
      check("t4_flag", int'(timeout_err[3]), 1);
      clear_err[3] = 1'b1; tick(1); clear_err = '0;
      check("t4_clear", int'(timeout_err[3]), 0);
      clear_err[3] = 1'b1;
      b = m_tmo[3]; n = 0;
      while (m_tmo[3] == b && n < 200) begin @(negedge clk); n++; end
      check("t4_tmo_wins", int'(timeout_err[3]), 1);
      clear_err = '0;
      tick(1);
      check("t4_sticky", int'(timeout_err[3]), 1);
      clear_err[3] = 1'b1; tick(1); clear_err = '0;

      // 5: enable drop in GRANT, then in CLASSIFY
      sensor_valid = '0;
      tick(3);
      enable = 1'b0;
      tick(1);
      check("t5_grant_idle", int'(sensor_ready), 0);
      tick(2);
      check("t5_stay_idle", int'(sensor_ready), 0);
      enable = 1'b1; sensor_valid = '1;
      wait_any_acc();
      enable = 1'b0;
      b = acc_total();
      tick(1);
      check("t5_update_ready", int'(sensor_ready), 0);
      tick(3);
      check("t5_idle_after", int'(sensor_ready), 0);
      check("t5_no_new_acc", acc_total(), b);

      // 6: reset mid-UPDATE with critical asserted
      for (int i = 0; i < N; i++) set_data(i, 120);
      enable = 1'b1;
      n = 0;
      while (!m_crit && n < 400) begin @(negedge clk); n++; end
      check("t6_crit_before", int'(critical), 1);
      wait_any_acc();
      tick(1);
      #2 reset = 1'b0;
      #1;
      check("t6_rst_ready", int'(sensor_ready), 0);
      check("t6_rst_level", int'(ch_level), 0);
      check("t6_rst_crit", int'(critical), 0);
      check("t6_rst_warn", int'(warning), 0);
      check("t6_rst_err", int'(timeout_err), 0);
      check("t6_rst_worst", int'(worst_ch), 0);
      @(negedge clk);
      reset = 1'b1;
      tick(1);
      check("t6_restart_ch0", int'(sensor_ready), 1);

      // randomized traffic with per-epoch channel reliability
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (cyc % 200 == 0)
            for (int i = 0; i < N; i++)
               case ($urandom_range(0, 2))
                  0:       vprob[i] = 0;
                  1:       vprob[i] = 30;
                  default: vprob[i] = 90;
               endcase
         for (int i = 0; i < N; i++) begin
            sensor_valid[i] = ($urandom_range(0, 99) < vprob[i]);
            case ($urandom_range(0, 3))
               0:       set_data(i, int'($urandom_range(48, 52)));
               1:       set_data(i, int'($urandom_range(98, 102)));
               2:       set_data(i, int'($urandom_range(0, 255)));
               default: set_data(i, int'($urandom_range(0, 40)));
            endcase
            clear_err[i] = ($urandom_range(0, 15) == 0);
         end
         enable = ($urandom_range(0, 31) != 0);
         @(negedge clk);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
